// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the operand sequencer: default data and register
// address widths, the ALU opcode encoding and the sequencer state encoding.
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL1 = 3'b101,
        OP_SHR1 = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Purely combinational arithmetic/logic unit for the operand sequencer.
// Ports:
//   a_i      - operand A (DW bits)
//   b_i      - operand B (DW bits)
//   op_i     - operation select (op_e)
//   result_o - DW-bit result
//   carry_o  - carry out (ADD), borrow (SUB), shifted-out bit (SHL1/SHR1),
//              zero for the logical ops and PASS
// ---------------------------------------------------------------------------
module seq_alu
    import seq_pkg::*;
#(
    parameter int DW = seq_pkg::DW
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  op_e           op_i,
    output logic [DW-1:0] result_o,
    output logic          carry_o
);

    // One extra bit on the adder so the carry falls out of the MSB.
    logic [DW:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = sum[DW-1:0];
                carry_o  = sum[DW];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHL1: begin
                result_o = {a_i[DW-2:0], 1'b0};
                carry_o  = a_i[DW-1];
            end
            OP_SHR1: begin
                result_o = {1'b0, a_i[DW-1:1]};
                carry_o  = a_i[0];
            end
            OP_PASS: result_o = b_i;
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
// Four-phase instruction sequencer: accepts one instruction, reads its
// operands from an external register file, executes it on seq_alu and writes
// the result back. Every phase takes one clock edge with cen high.
// Ports:
//   clk, rst (sync, active-low), cen (clock enable)
//   instr_valid_i / instr_ready_o      - instruction handshake
//   op_i, rs_i, rs2_i, rd_i            - opcode and register addresses
//   imm_i, use_imm_i                   - immediate and immediate-as-B select
//   rf_rs_o, rf_rs2_o                  - register-file read addresses
//   rf_rs_dat_i, rf_rs2_dat_i          - combinational register-file data
//   rf_rd_o, rf_dat_o, rf_we_o         - register-file write port
//   result_o, zero_o, carry_o          - last result and flags
//   done_o                             - one-cycle completion pulse
// The external register file uses an active-high reset; the integrating
// level feeds it the inverse of rst.
// ---------------------------------------------------------------------------
module operand_sequencer
    import seq_pkg::*;
#(
    parameter int DW = seq_pkg::DW,
    parameter int AW = seq_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  logic [2:0]    op_i,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rs2_i,
    input  logic [AW-1:0] rd_i,
    input  logic [DW-1:0] imm_i,
    input  logic          use_imm_i,
    output logic [AW-1:0] rf_rs_o,
    output logic [AW-1:0] rf_rs2_o,
    input  logic [DW-1:0] rf_rs_dat_i,
    input  logic [DW-1:0] rf_rs2_dat_i,
    output logic [AW-1:0] rf_rd_o,
    output logic [DW-1:0] rf_dat_o,
    output logic          rf_we_o,
    output logic [DW-1:0] result_o,
    output logic          zero_o,
    output logic          carry_o,
    output logic          done_o
);

    state_e        state_q,   state_d;
    op_e           op_q,      op_d;
    logic [AW-1:0] rs_q,      rs_d;
    logic [AW-1:0] rs2_q,     rs2_d;
    logic [AW-1:0] rd_q,      rd_d;
    logic [DW-1:0] imm_q,     imm_d;
    logic          use_imm_q, use_imm_d;
    logic [DW-1:0] a_q,       a_d;
    logic [DW-1:0] b_q,       b_d;
    logic [DW-1:0] result_q,  result_d;
    logic          zero_q,    zero_d;
    logic          carry_q,   carry_d;

    logic [DW-1:0] alu_result;
    logic          alu_carry;

    seq_alu #(.DW(DW)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // Next-state logic. Everything holds unless cen is high, so a low cen
    // freezes the sequencer mid-instruction without losing any context.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;

        if (cen) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        op_d      = op_e'(op_i);
                        rs_d      = rs_i;
                        rs2_d     = rs2_i;
                        rd_d      = rd_i;
                        imm_d     = imm_i;
                        use_imm_d = use_imm_i;
                        state_d   = ST_READ;
                    end
                end
                ST_READ: begin
                    // Operands are captured here, before write-back, so an
                    // instruction whose rd aliases rs/rs2 sees the old value.
                    a_d     = rf_rs_dat_i;
                    b_d     = use_imm_q ? imm_q : rf_rs2_dat_i;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    result_d = alu_result;
                    carry_d  = alu_carry;
                    zero_d   = (alu_result == '0);
                    state_d  = ST_WB;
                end
                ST_WB: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and latched-field registers with synchronous active-low reset;
    // reset wins over cen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            rs_q      <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    // Register-file addresses and write data come only from latched state,
    // so there is no combinational path from the instruction inputs. The
    // write enable and done pulse are gated by cen so a stalled WB never
    // writes.
    always_comb begin
        instr_ready_o = (state_q == ST_IDLE);
        rf_rs_o       = rs_q;
        rf_rs2_o      = rs2_q;
        rf_rd_o       = rd_q;
        rf_dat_o      = result_q;
        rf_we_o       = (state_q == ST_WB) && cen;
        done_o        = (state_q == ST_WB) && cen;
        result_o      = result_q;
        zero_o        = zero_q;
        carry_o       = carry_q;
    end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter DW, default 8, data width.
REQ-002 SHALL have parameter AW, default 3, register address width (8 registers).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 cen  in  1  clock enable; state advances only on edges where cen=1.
REQ-006 instr_valid_i  in  1  instruction offered.
REQ-007 instr_ready_o  out  1  block can accept an instruction.
REQ-008 op_i  in  3  opcode, see REQ-016.
REQ-009 rs_i, rs2_i, rd_i  in  AW each  source A, source B and destination register.
REQ-010 imm_i  in  DW, use_imm_i  in  1  immediate, and immediate-as-B select.
REQ-011 rf_rs_o, rf_rs2_o  out  AW each  register-file read addresses.
REQ-012 rf_rs_dat_i, rf_rs2_dat_i  in  DW each  combinational register-file read data.
REQ-013 rf_rd_o  out  AW, rf_dat_o  out  DW, rf_we_o  out  1  register-file write port.
REQ-014 result_o  out  DW, zero_o  out  1, carry_o  out  1, done_o  out  1  last result, flags and completion pulse.

Function
REQ-015 FSM SHALL have states IDLE -> READ -> EXEC -> WB -> IDLE, one cen-qualified edge per transition, with no other transitions except reset.
- IDLE: instr_ready_o=1; on an edge with cen & instr_valid_i, latch op/rs/rs2/rd/imm/use_imm and go to READ.
- READ: rf_rs_o/rf_rs2_o = latched rs/rs2; capture A=rf_rs_dat_i and B=(use_imm ? imm : rf_rs2_dat_i) at the edge.
- EXEC: compute; register result_o, zero_o and carry_o at the edge.
- WB: rf_rd_o = latched rd; rf_dat_o = result_o; rf_we_o = cen; done_o = cen.
REQ-016 Opcodes SHALL be as follows; result is DW bits and carry is 1 bit:
- 000 ADD: carry = bit DW of A+B.
- 001 SUB: result = A-B mod 2^DW; carry = (A<B), the borrow.
- 010 AND, 011 OR, 100 XOR: carry = 0.
- 101 SHL1: carry = A[DW-1].
- 110 SHR1 (logical): carry = A[0].
- 111 PASS: result = B; carry = 0.
REQ-017 zero_o SHALL be 1 exactly when the registered result is 0.
REQ-018 Latency: for an accept at edge N, rf_we_o SHALL be high during cycle N+3 and the register file SHALL be written at edge N+3; the earliest next accept is edge N+4 (with cen held at 1).
REQ-019 instr_ready_o SHALL be 0 in READ, EXEC and WB; instr_valid_i SHALL be ignored there.
REQ-020 With cen=0, all state and outputs SHALL hold, except rf_we_o=0 and done_o=0.
REQ-021 rd = rs or rs2 SHALL be legal; operands are captured before write-back, so the old value is used.
REQ-022 Register 0 SHALL be an ordinary writable register.
REQ-023 result_o, zero_o and carry_o SHALL hold until the next EXEC edge.
REQ-024 rf_rs_o, rf_rs2_o, rf_rd_o and rf_dat_o SHALL be driven from latched values in every state; no combinational path from instr inputs.

Reset
REQ-025 On an edge with rst=0, regardless of cen: state=IDLE, all latched fields=0, result_o=0, zero_o=0, carry_o=0.
REQ-026 Reset mid-instruction SHALL abandon it with no register-file write; rf_we_o=0 and done_o=0 on the cycle after the reset edge.
REQ-027 The register file's reset is active-high; top-level integration SHALL invert rst for it.

Structure
REQ-028 Shared package seq_pkg SHALL hold DW, AW, opcode enum op_e, and FSM enum state_e.
REQ-029 Arithmetic SHALL live in one combinational sub-module seq_alu (A, B, op -> result, carry).
REQ-030 Target size is 120-400 RTL lines.

Verification
REQ-031 Reset, then write R1=0x05 and R2=0x03 (PASS, imm) -> R1=0x05, R2=0x03; ADD rd=3, rs=1, rs2=2 -> R3=0x08, zero_o=0, carry_o=0, done_o one cycle after 3 edges.
REQ-032 R1=0xFF; ADD R1+imm 0x01 -> result 0x00, zero_o=1, carry_o=1; SUB 0x03-0x05 -> 0xFE, carry_o=1.
REQ-033 SHL1 of 0x81 -> 0x02, carry_o=1; SHR1 of 0x81 -> 0x40, carry_o=1; XOR of R with itself -> 0x00, zero_o=1.
REQ-034 Toggle cen 1,0,1,0 during an ADD -> write occurs only after 4 cen-high edges; rf_we_o never high while cen=0; instr_valid_i held high during busy -> exactly one accept per 4 cen-high edges.
REQ-035 Assert rst=0 in the EXEC state -> no write to rd, outputs 0, instr_ready_o=1 on the next cycle.
REQ-036 ADD rd=1, rs=1, rs2=1 with R1=0x10 -> R1=0x20.
